rr_arbiter_4: RTL

Four-channel round-robin arbiter that grants one requester at a time and presents the winner as a 2-bit binary index plus a valid flag. It sits directly upstream of the 2-to-4 decoder. `I` drives the decoder's select input, and `valid` gates its one-hot output into per-channel grant/enable lines. Grants are held until the owner signals completion, drops its request, or exceeds a hold limit. Release then rotates priority to the next channel.

---
 rtl/rr_arbiter_4.sv | 99 +++++++++
 1 files changed

// File: rtl/rr_arbiter_4.sv
// Four-channel round-robin arbiter: one grant at a time, presented as a
// registered 2-bit index plus valid flag, released on done/drop/hold limit.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] I,
  output logic       valid
);

  localparam int CW = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state_r, state_s;
  logic [1:0]     i_r, i_s;
  logic           valid_r, valid_s;
  logic [1:0]     last_r, last_s;
  logic [CW-1:0]  hold_cnt_r, hold_cnt_s;
  logic           release_s;

  // First requesting channel searching last+1, last+2, last+3, last (mod 4).
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] cand;
    logic       found;
    pick  = l;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand  = l + k[1:0];
      pick  = (!found && r[cand]) ? cand : pick;
      found = found | r[cand];
    end
  endfunction

  assign release_s = done | ~req[i_r] | (hold_cnt_r == HOLD_LAST);

  // Next-state and next-output logic.
  always_comb begin
    state_s    = state_r;
    i_s        = i_r;
    valid_s    = valid_r;
    last_s     = last_r;
    hold_cnt_s = hold_cnt_r;
    case (state_r)
      IDLE: begin
        if (req != 4'b0000) begin
          i_s        = pick(req, last_r);
          valid_s    = 1'b1;
          hold_cnt_s = '0;
          state_s    = GRANT;
        end else begin
          valid_s = 1'b0;
        end
      end
      GRANT: begin
        // Any combination of release causes rotates priority exactly once.
        if (release_s) begin
          valid_s = 1'b0;
          last_s  = i_r;
          state_s = IDLE;
        end else begin
          hold_cnt_s = hold_cnt_r + CW'(1);
        end
      end
      default: begin
        valid_s = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      i_r        <= 2'b00;
      valid_r    <= 1'b0;
      last_r     <= 2'b11;
      hold_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      i_r        <= i_s;
      valid_r    <= valid_s;
      last_r     <= last_s;
      hold_cnt_r <= hold_cnt_s;
    end
  end

  assign I     = i_r;
  assign valid = valid_r;

endmodule
